// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: synchronized, debounced push buttons feeding a round-robin valid/ready event port.
// Optional release events (falling edges) are enabled with BTN_RELEASE_EVT_EN.
module btn_event_arbiter #(
  parameter int N = 4,
  parameter int DB_CNT = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   btn_async,
  output logic [N-1:0]   btn_level,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rel,
  output logic           evt_overrun
);
`ifdef BTN_RELEASE_EVT_EN
  localparam int M = 2 * N;
`else
  localparam int M = N;
`endif
  localparam int SW = $clog2(M);
  localparam int CW = $clog2(DB_CNT);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t st, st_n;
  logic [N-1:0] s1, s2, stable, hit;
  logic [CW-1:0] cnt [N];
  logic [M-1:0] req, req_n, ev, clr;
  logic [SW-1:0] last, slot, gslot;
  logic gany, ovr;
  always_comb
    for (int i = 0; i < N; i++)
      hit[i] = (s2[i] != stable[i]) && (cnt[i] == CW'(DB_CNT - 1));
`ifdef BTN_RELEASE_EVT_EN
  assign ev = {hit & ~s2, hit & s2};
  assign evt_rel = slot >= SW'(N);
  assign evt_id = IDW'(evt_rel ? slot - SW'(N) : slot);
`else
  assign ev = hit & s2;
  assign evt_rel = 1'b0;
  assign evt_id = slot;
`endif
  assign btn_level = stable;
  assign evt_valid = (st == HOLD);
  // Lowest request above last wins; otherwise wrap to the lowest request overall.
  always_comb begin
    gany = |req;
    gslot = last;
    for (int i = M - 1; i >= 0; i--)
      if (req[i]) gslot = SW'(i);
    for (int i = M - 1; i >= 0; i--)
      if (req[i] && SW'(i) > last) gslot = SW'(i);
  end
  // A grant and a new edge in the same cycle leave the flag set without overrun.
  always_comb begin
    st_n = st;
    clr = '0;
    if (st == IDLE && gany) begin
      st_n = HOLD;
      clr = M'(1) << gslot;
    end
    if (st == HOLD && evt_ready) st_n = IDLE;
    req_n = (req & ~clr) | ev;
    ovr = |(ev & req & ~clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      req <= '0;
      evt_overrun <= 1'b0;
      slot <= '0;
      last <= SW'(M - 1);
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_async;
      s2 <= s1;
      stable <= stable ^ hit;
      req <= req_n;
      evt_overrun <= ovr;
      if (st == IDLE && gany) slot <= gslot;
      if (st == HOLD && evt_ready) last <= slot;
      for (int i = 0; i < N; i++)
        cnt[i] <= (s2[i] == stable[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
    end
endmodule
